// File: rtl/syn_md_rx_pkg.sv
// Shared definitions for the syn_md sync-pulse link: FSM encoding and default pulse limits.
package syn_md_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int unsigned DEF_FILT_LEN = 4;
  localparam int unsigned DEF_WID_W    = 16;
  localparam int unsigned DEF_PER_W    = 24;
  localparam int unsigned DEF_MIN_W    = 8;
  localparam int unsigned DEF_MAX_W    = 200;
  localparam int unsigned DEF_TOL      = 16;
  localparam int unsigned DEF_LOCK_N   = 3;
  localparam int unsigned DEF_TIMEOUT  = 10000000;

endpackage

// File: rtl/syn_md_deglitch.sv
// Two-flop synchroniser plus level filter; emits filtered level and one-cycle rise/fall strobes.
module syn_md_deglitch #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // A new level is accepted once it has differed from the current one for FILT_LEN cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
        level <= sync2;
        rise  <= sync2;
        fall  <= ~sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/syn_md_rx.sv
// Receive side of the syn_md sync pulse: width/period measurement, validation, lock and error tracking.
module syn_md_rx
  import syn_md_rx_pkg::*;
#(
  parameter int unsigned FILT_LEN = DEF_FILT_LEN,
  parameter int unsigned WID_W    = DEF_WID_W,
  parameter int unsigned PER_W    = DEF_PER_W,
  parameter int unsigned MIN_W    = DEF_MIN_W,
  parameter int unsigned MAX_W    = DEF_MAX_W,
  parameter int unsigned TOL      = DEF_TOL,
  parameter int unsigned LOCK_N   = DEF_LOCK_N,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             syn_md_in,
  input  logic             clr_err,
  output logic             syn_md_tick,
  output logic [WID_W-1:0] width_out,
  output logic [PER_W-1:0] period_out,
  output logic             period_vld,
  output logic             locked,
  output logic             bad_pulse,
  output logic             err_width,
  output logic             err_timeout
);

  localparam int unsigned LCK_W = $clog2(LOCK_N + 1);

  state_t             state;
  logic [WID_W-1:0]   wid_cnt;
  logic [PER_W-1:0]   per_cnt;
  logic [PER_W-1:0]   prev_per;
  logic               have_prev;
  logic [LCK_W-1:0]   lock_cnt;
  logic               lvl;
  logic               rise;
  logic               fall;
  logic [PER_W:0]     per_diff;
  logic [PER_W:0]     per_abs;
  logic               per_match;
  logic [LCK_W-1:0]   lock_inc;

  syn_md_deglitch #(.FILT_LEN(FILT_LEN)) u_deglitch (
    .clk   (clkin),
    .rst   (rst),
    .din   (syn_md_in),
    .level (lvl),
    .rise  (rise),
    .fall  (fall)
  );

  // Period match against the previous period, one bit wider so the difference cannot underflow.
  always_comb begin
    per_diff  = {1'b0, per_cnt} - {1'b0, prev_per};
    per_abs   = per_diff[PER_W] ? -per_diff : per_diff;
    per_match = have_prev && (per_abs <= (PER_W+1)'(TOL));
    lock_inc  = (lock_cnt == LCK_W'(LOCK_N)) ? lock_cnt : lock_cnt + 1'b1;
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state       <= ST_IDLE;
      wid_cnt     <= '0;
      per_cnt     <= '0;
      prev_per    <= '0;
      have_prev   <= 1'b0;
      lock_cnt    <= '0;
      syn_md_tick <= 1'b0;
      width_out   <= '0;
      period_out  <= '0;
      period_vld  <= 1'b0;
      locked      <= 1'b0;
      bad_pulse   <= 1'b0;
      err_width   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      syn_md_tick <= 1'b0;
      period_vld  <= 1'b0;
      bad_pulse   <= 1'b0;
      // Clear first so an error raised below in the same cycle keeps its flag set.
      if (clr_err) begin
        err_width   <= 1'b0;
        err_timeout <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state     <= ST_HIGH;
            wid_cnt   <= WID_W'(1);
            per_cnt   <= PER_W'(1);
            have_prev <= 1'b0;
          end
        end
        ST_HIGH: begin
          if (fall && wid_cnt >= WID_W'(MIN_W) && wid_cnt <= WID_W'(MAX_W)) begin
            state       <= ST_LOW;
            syn_md_tick <= 1'b1;
            width_out   <= wid_cnt;
            per_cnt     <= per_cnt + 1'b1;
          end else if (fall || (lvl && wid_cnt == WID_W'(MAX_W))) begin
            state     <= ST_IDLE;
            bad_pulse <= 1'b1;
            err_width <= 1'b1;
            lock_cnt  <= '0;
            locked    <= 1'b0;
            have_prev <= 1'b0;
          end else if (per_cnt == PER_W'(TIMEOUT - 1)) begin
            state       <= ST_IDLE;
            err_timeout <= 1'b1;
            lock_cnt    <= '0;
            locked      <= 1'b0;
          end else begin
            wid_cnt <= wid_cnt + 1'b1;
            per_cnt <= per_cnt + 1'b1;
          end
        end
        ST_LOW: begin
          if (rise) begin
            state      <= ST_HIGH;
            period_out <= per_cnt;
            period_vld <= 1'b1;
            lock_cnt   <= per_match ? lock_inc : '0;
            locked     <= per_match && (lock_inc == LCK_W'(LOCK_N));
            prev_per   <= per_cnt;
            have_prev  <= 1'b1;
            wid_cnt    <= WID_W'(1);
            per_cnt    <= PER_W'(1);
          end else if (per_cnt == PER_W'(TIMEOUT - 1)) begin
            state       <= ST_IDLE;
            err_timeout <= 1'b1;
            lock_cnt    <= '0;
            locked      <= 1'b0;
          end else begin
            per_cnt <= per_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syn_md_rx.sv
// Directed bench for syn_md_rx: a table of pulses with expected per-pulse results, plus hand sequences.
module tb_syn_md_rx;

  logic        clkin = 1'b0;
  logic        rst;
  logic        syn_md_in;
  logic        clr_err;
  logic        syn_md_tick;
  logic [15:0] width_out;
  logic [23:0] period_out;
  logic        period_vld;
  logic        locked;
  logic        bad_pulse;
  logic        err_width;
  logic        err_timeout;

  syn_md_rx #(
    .FILT_LEN(4), .WID_W(16), .PER_W(24), .MIN_W(8), .MAX_W(200),
    .TOL(16), .LOCK_N(3), .TIMEOUT(10000)
  ) dut (
    .clkin       (clkin),
    .rst         (rst),
    .syn_md_in   (syn_md_in),
    .clr_err     (clr_err),
    .syn_md_tick (syn_md_tick),
    .width_out   (width_out),
    .period_out  (period_out),
    .period_vld  (period_vld),
    .locked      (locked),
    .bad_pulse   (bad_pulse),
    .err_width   (err_width),
    .err_timeout (err_timeout)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    int hi;      // cycles line held high
    int lo;      // cycles line held low afterwards
    bit glitch;  // 3-cycle glitch in the middle of the low phase
    bit clr;     // pulse clr_err in the first high cycle
    int e_tick;
    int e_w;
    int e_pv;
    int e_per;
    int e_bad;
    int e_lock;
    int e_errw;
  } row_t;

  row_t rows[21];
  int   total = 0;
  int   bad_cnt = 0;
  int   n_tick = 0, n_pv = 0, n_badp = 0;
  int   last_w = 0, last_p = 0;

  // Event counters sampled on the falling edge.
  always @(negedge clkin) begin
    if (syn_md_tick) begin n_tick <= n_tick + 1; last_w <= int'(width_out); end
    if (period_vld)  begin n_pv   <= n_pv + 1;   last_p <= int'(period_out); end
    if (bad_pulse)   n_badp <= n_badp + 1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      int t0, p0, b0;
      t0 = n_tick; p0 = n_pv; b0 = n_badp;
      syn_md_in = 1'b1;
      if (rows[i].clr) begin
        clr_err = 1'b1; cyc(1); clr_err = 1'b0; cyc(rows[i].hi - 1);
      end else begin
        cyc(rows[i].hi);
      end
      syn_md_in = 1'b0;
      if (rows[i].glitch) begin
        cyc(rows[i].lo / 2);
        syn_md_in = 1'b1; cyc(3); syn_md_in = 1'b0;
        cyc(rows[i].lo - rows[i].lo / 2 - 3);
      end else begin
        cyc(rows[i].lo);
      end
      check($sformatf("r%0d ticks", i), n_tick - t0, rows[i].e_tick);
      check($sformatf("r%0d period_vld", i), n_pv - p0, rows[i].e_pv);
      check($sformatf("r%0d bad_pulse", i), n_badp - b0, rows[i].e_bad);
      check($sformatf("r%0d locked", i), locked, rows[i].e_lock);
      check($sformatf("r%0d err_width", i), err_width, rows[i].e_errw);
      if (rows[i].e_tick != 0) check($sformatf("r%0d width", i), last_w, rows[i].e_w);
      if (rows[i].e_pv != 0) check($sformatf("r%0d period", i), last_p, rows[i].e_per);
    end
  endtask

  initial begin
    int t0, p0, b0;
    //          hi   lo  gl clr tick  w   pv  per  bad lock errw
    rows[0]  = '{ 50, 950, 0, 0, 1,  50, 0,    0, 0, 0, 0};
    rows[1]  = '{ 50, 950, 0, 0, 1,  50, 1, 1000, 0, 0, 0};
    rows[2]  = '{ 50, 950, 0, 0, 1,  50, 1, 1000, 0, 0, 0};
    rows[3]  = '{ 50, 950, 0, 0, 1,  50, 1, 1000, 0, 0, 0};
    rows[4]  = '{ 50, 950, 0, 0, 1,  50, 1, 1000, 0, 1, 0};
    rows[5]  = '{ 50, 950, 1, 0, 1,  50, 1, 1000, 0, 1, 0};
    rows[6]  = '{  5, 995, 0, 0, 0,   0, 1, 1000, 1, 0, 1};
    rows[7]  = '{ 50, 950, 0, 1, 1,  50, 0,    0, 0, 0, 0};
    rows[8]  = '{  7, 993, 0, 0, 0,   0, 0,    0, 1, 0, 1};
    rows[9]  = '{  8, 992, 0, 1, 1,   8, 0,    0, 0, 0, 0};
    rows[10] = '{200, 800, 0, 0, 1, 200, 1, 1000, 0, 0, 0};
    rows[11] = '{201, 799, 0, 0, 0,   0, 1, 1000, 1, 0, 1};
    rows[12] = '{300, 700, 0, 1, 0,   0, 0,    0, 1, 0, 1};
    rows[13] = '{ 50, 950, 0, 0, 1,  50, 0,    0, 0, 0, 1};
    rows[14] = '{ 50, 960, 0, 0, 1,  50, 1, 1000, 0, 0, 1};
    rows[15] = '{ 50, 980, 0, 0, 1,  50, 1, 1010, 0, 0, 1};
    rows[16] = '{ 50, 950, 0, 0, 1,  50, 1, 1030, 0, 0, 1};
    rows[17] = '{ 50, 966, 0, 0, 1,  50, 1, 1000, 0, 0, 1};
    rows[18] = '{ 50, 950, 0, 0, 1,  50, 1, 1016, 0, 0, 1};
    rows[19] = '{ 50, 950, 0, 0, 1,  50, 1, 1000, 0, 0, 1};
    rows[20] = '{ 50, 950, 0, 0, 1,  50, 1, 1000, 0, 1, 1};

    rst = 1'b1; syn_md_in = 1'b0; clr_err = 1'b0;
    cyc(4);
    check("reset tick", syn_md_tick, 0);
    check("reset outs", {width_out, period_out, period_vld, locked, bad_pulse}, 0);
    check("reset errs", {err_width, err_timeout}, 0);
    rst = 1'b0;
    cyc(2);

    run_rows(0, 7);

    // Width-5 pulse whose fall is seen by the FSM in the same cycle clr_err is high.
    syn_md_in = 1'b1; cyc(5);
    syn_md_in = 1'b0; cyc(6);
    clr_err = 1'b1; cyc(1); clr_err = 1'b0;
    check("coinc bad_pulse", bad_pulse, 1);
    check("coinc err_width", err_width, 1);
    cyc(988);

    run_rows(8, 20);

    // No further edges: timeout must wait for the full count after the last rise.
    cyc(8000);
    check("pre-timeout err", err_timeout, 0);
    check("pre-timeout lock", locked, 1);
    for (int c = 0; c < 3000 && !err_timeout; c++) cyc(1);
    check("timeout err", err_timeout, 1);
    check("timeout lock", locked, 0);
    clr_err = 1'b1; cyc(1); clr_err = 1'b0;
    check("clr timeout", err_timeout, 0);

    // Reset in the middle of a high pulse; the fall happens while reset is held.
    syn_md_in = 1'b1; cyc(20);
    rst = 1'b1; cyc(1);
    check("midrst outs", {syn_md_tick, width_out, period_out, period_vld, locked, bad_pulse}, 0);
    check("midrst errs", {err_width, err_timeout}, 0);
    cyc(3); syn_md_in = 1'b0; cyc(20);
    rst = 1'b0;
    t0 = n_tick; p0 = n_pv; b0 = n_badp;
    cyc(1000);
    check("post-rst ticks", n_tick - t0, 0);
    check("post-rst pv", n_pv - p0, 0);
    check("post-rst bad", n_badp - b0, 0);
    check("post-rst errw", err_width, 0);

    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
